// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Arbitrates one synchronous single-port data RAM between the core load/store
// unit and a debug host. Each access takes exactly three cycles:
//   IDLE   : pick a winner and latch its we/addr/wdata
//   ACCESS : drive the RAM from the latched request
//   RESP   : pulse the winner's done/ack; on a read, capture mem_rdata into
//            its rdata register at the end of this cycle
//
// Build option:
//   DMEM_HOST_PRIO_EN  defined   -> host always wins a tie (no last_grant)
//                      undefined -> round-robin between core and host
//
// Parameters:
//   addr_width  RAM address width (default 16)
//   data_width  RAM word width    (default 32)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   core_req/we/addr/wdata   core request, held until core_done
//   core_rdata               registered core load data
//   core_done                one-cycle core completion pulse
//   core_stall               core halt = core_req & ~core_done
//   host_req/we/addr/wdata   debug-host request, same semantics as core
//   host_rdata, host_ack     registered host read data, host completion pulse
//   mem_en, mem_we           RAM enable / write strobe (only in ACCESS)
//   mem_addr, mem_wdata      RAM address / write data (0 outside ACCESS)
//   mem_rdata                RAM read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int addr_width = 16,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [addr_width-1:0] core_addr,
    input  logic [data_width-1:0] core_wdata,
    output logic [data_width-1:0] core_rdata,
    output logic                  core_done,
    output logic                  core_stall,

    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [addr_width-1:0] host_addr,
    input  logic [data_width-1:0] host_wdata,
    output logic [data_width-1:0] host_rdata,
    output logic                  host_ack,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACCESS = 2'b01;
    localparam logic [1:0] S_RESP   = 2'b10;

    logic [1:0]            r_state;
    logic                  r_we;
    logic [addr_width-1:0] r_addr;
    logic [data_width-1:0] r_wdata;
    logic                  r_grant_host;   // 1 = current access belongs to host
    logic [data_width-1:0] r_core_rdata;
    logic [data_width-1:0] r_host_rdata;
`ifndef DMEM_HOST_PRIO_EN
    logic                  r_last_host;    // 1 = host was granted last
`endif

    logic                  w_any_req;
    logic                  w_win_host;
    logic                  w_in_access;
    logic                  w_in_resp;

    assign w_any_req = core_req | host_req;

    // Winner selection, only meaningful while w_any_req is high.
    always_comb begin
        w_win_host = 1'b0;
`ifdef DMEM_HOST_PRIO_EN
        w_win_host = host_req;
`else
        // On a tie the side not granted last wins.
        w_win_host = host_req & (~core_req | ~r_last_host);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_grant_host <= 1'b0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
`ifndef DMEM_HOST_PRIO_EN
            r_last_host  <= 1'b1;   // core wins the first tie
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_we         <= w_win_host ? host_we    : core_we;
                        r_addr       <= w_win_host ? host_addr  : core_addr;
                        r_wdata      <= w_win_host ? host_wdata : core_wdata;
                        r_grant_host <= w_win_host;
`ifndef DMEM_HOST_PRIO_EN
                        r_last_host  <= w_win_host;
`endif
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (!r_we) begin
                        if (r_grant_host) r_host_rdata <= mem_rdata;
                        else              r_core_rdata <= mem_rdata;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by rst so a reset mid-access immediately silences
    // the RAM and suppresses the completion pulse.
    assign w_in_access = (r_state == S_ACCESS) & ~rst;
    assign w_in_resp   = (r_state == S_RESP)   & ~rst;

    assign mem_en     = w_in_access;
    assign mem_we     = w_in_access & r_we;
    assign mem_addr   = w_in_access ? r_addr  : '0;
    assign mem_wdata  = w_in_access ? r_wdata : '0;

    assign core_done  = w_in_resp & ~r_grant_host;
    assign host_ack   = w_in_resp &  r_grant_host;
    assign core_stall = core_req & ~core_done;

    assign core_rdata = r_core_rdata;
    assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a small synchronous RAM model.
// Inputs are driven and outputs checked on the falling clock edge. The drive
// point of a request is cycle 1 (IDLE); the next falling edge is ACCESS and
// the one after that is RESP.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_done, core_stall;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_done  (core_done),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous RAM model with a preload port used during reset.
    logic [DW-1:0] mem [0:1023];
    logic          preload;

    always @(posedge clk) begin
        if (preload) begin
            mem[10'h040] <= 32'h1234_ABCD;
            mem[10'h100] <= 32'h0000_0000;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

`ifdef DMEM_HOST_PRIO_EN
    localparam logic [3:0] RR_HOST = 4'b1111;
`else
    localparam logic [3:0] RR_HOST = 4'b1010;  // bit k: access k goes to host
`endif

    initial begin
        logic [3:0] rr_host;
        rr_host    = RR_HOST;
        rst        = 1'b1;
        preload    = 1'b1;
        core_req   = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req   = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        // ---------------- reset state ----------------
        nedge(); nedge();
        chk("rst_mem_en",     {31'b0, mem_en},    32'd0);
        chk("rst_core_done",  {31'b0, core_done}, 32'd0);
        chk("rst_host_ack",   {31'b0, host_ack},  32'd0);
        chk("rst_core_rdata", core_rdata,         32'd0);
        chk("rst_host_rdata", host_rdata,         32'd0);
        rst = 1'b0; preload = 1'b0;

        // ---------------- core read of 0x0040 ----------------
        nedge();
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0040;
        #1;
        chk("rd_c1_stall",   {31'b0, core_stall}, 32'd1);
        chk("rd_c1_mem_en",  {31'b0, mem_en},     32'd0);
        nedge();                                   // ACCESS
        chk("rd_c2_mem_en",  {31'b0, mem_en},     32'd1);
        chk("rd_c2_mem_we",  {31'b0, mem_we},     32'd0);
        chk("rd_c2_addr",    {16'b0, mem_addr},   32'h0040);
        chk("rd_c2_stall",   {31'b0, core_stall}, 32'd1);
        chk("rd_c2_done",    {31'b0, core_done},  32'd0);
        nedge();                                   // RESP
        chk("rd_c3_done",    {31'b0, core_done},  32'd1);
        chk("rd_c3_stall",   {31'b0, core_stall}, 32'd0);
        chk("rd_c3_mem_en",  {31'b0, mem_en},     32'd0);
        chk("rd_c3_ack",     {31'b0, host_ack},   32'd0);
        core_req = 1'b0;
        nedge();                                   // IDLE
        chk("rd_c4_rdata",   core_rdata,          32'h1234_ABCD);
        chk("rd_c4_done",    {31'b0, core_done},  32'd0);

        // ---------------- host write 0xDEADBEEF @ 0x0100 ----------------
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0100; host_wdata = 32'hDEAD_BEEF;
        #1;
        chk("hw_c1_ack",     {31'b0, host_ack},   32'd0);
        chk("hw_c1_cstall",  {31'b0, core_stall}, 32'd0);
        nedge();
        host_wdata = 32'h5555_5555;               // late change must be ignored
        #1;
        chk("hw_c2_mem_en",  {31'b0, mem_en},     32'd1);
        chk("hw_c2_mem_we",  {31'b0, mem_we},     32'd1);
        chk("hw_c2_addr",    {16'b0, mem_addr},   32'h0100);
        chk("hw_c2_wdata",   mem_wdata,           32'hDEAD_BEEF);
        nedge();
        chk("hw_c3_ack",     {31'b0, host_ack},   32'd1);
        chk("hw_c3_cdone",   {31'b0, core_done},  32'd0);
        host_req = 1'b0; host_we = 1'b0;
        nedge();
        chk("hw_c4_mem_en",  {31'b0, mem_en},     32'd0);
        chk("hw_c4_hrdata",  host_rdata,          32'd0);
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0100;
        nedge();
        chk("cr_c2_addr",    {16'b0, mem_addr},   32'h0100);
        nedge();
        chk("cr_c3_done",    {31'b0, core_done},  32'd1);
        core_req = 1'b0;
        nedge();
        chk("cr_c4_rdata",   core_rdata,          32'hDEAD_BEEF);

        // ---------------- simultaneous requests after reset ----------------
        rst = 1'b1;
        nedge();
        chk("rst2_mem_en",   {31'b0, mem_en},     32'd0);
        chk("rst2_rdata",    core_rdata,          32'd0);
        rst = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0040;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0100;
        for (int k = 0; k < 4; k++) begin
            nedge();                               // ACCESS
            chk($sformatf("rr%0d_mem_en", k), {31'b0, mem_en}, 32'd1);
            chk($sformatf("rr%0d_addr", k), {16'b0, mem_addr},
                rr_host[k] ? 32'h0100 : 32'h0040);
            nedge();                               // RESP
            chk($sformatf("rr%0d_cdone", k), {31'b0, core_done}, {31'b0, ~rr_host[k]});
            chk($sformatf("rr%0d_hack", k),  {31'b0, host_ack},  {31'b0,  rr_host[k]});
            if (k == 3) begin
                core_req = 1'b0; host_req = 1'b0;
            end
            nedge();                               // IDLE
            chk($sformatf("rr%0d_idle_en", k), {31'b0, mem_en}, 32'd0);
        end
        chk("rr_hrdata", host_rdata, 32'hDEAD_BEEF);
`ifdef DMEM_HOST_PRIO_EN
        chk("rr_crdata", core_rdata, 32'd0);
`else
        chk("rr_crdata", core_rdata, 32'h1234_ABCD);
`endif

        // ---------------- reset during ACCESS of a core read ----------------
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0040;
        nedge();                                   // ACCESS
        chk("ra_c2_mem_en",  {31'b0, mem_en},     32'd1);
        rst = 1'b1;
        #1;
        chk("ra_rst_mem_en", {31'b0, mem_en},     32'd0);
        nedge();                                   // cycle after reset
        chk("ra_done",       {31'b0, core_done},  32'd0);
        chk("ra_mem_en",     {31'b0, mem_en},     32'd0);
        chk("ra_rdata",      core_rdata,          32'd0);
        rst = 1'b0;
        nedge();                                   // re-served: ACCESS
        chk("ra_re_mem_en",  {31'b0, mem_en},     32'd1);
        chk("ra_re_addr",    {16'b0, mem_addr},   32'h0040);
        nedge();
        chk("ra_re_done",    {31'b0, core_done},  32'd1);
        core_req = 1'b0;
        nedge();
        chk("ra_re_rdata",   core_rdata,          32'h1234_ABCD);

        // ---------------- core drops req during ACCESS ----------------
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0100;
        nedge();                                   // ACCESS
        core_req = 1'b0; core_addr = 16'h03FF;
        #1;
        chk("dr_addr",       {16'b0, mem_addr},   32'h0100);
        chk("dr_mem_en",     {31'b0, mem_en},     32'd1);
        nedge();                                   // RESP
        chk("dr_done",       {31'b0, core_done},  32'd1);
        chk("dr_stall",      {31'b0, core_stall}, 32'd0);
        nedge();                                   // IDLE
        chk("dr_idle_en",    {31'b0, mem_en},     32'd0);
        chk("dr_idle_done",  {31'b0, core_done},  32'd0);
        chk("dr_rdata",      core_rdata,          32'hDEAD_BEEF);
        nedge();
        chk("dr_no_new_en",  {31'b0, mem_en},     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
